// File: rtl/baggage_timer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : baggage_timer_ctrl_if
// Description : Bundle of the control inputs and measurement outputs of the
//               baggage timer. The master side (upstream sensor logic) drives
//               start/weight/arrive/clear. The slave side (the timer) drives
//               t_act/t_lim/drop_en/busy/overflow.
// Ports       : none (clock and reset stay plain ports on the timer)
//   start    1   baggage entered (1-cycle pulse)
//   weight   8   baggage weight
//   arrive   1   baggage reached gate
//   clear    1   abort / acknowledge
//   t_act    16  elapsed ticks
//   t_lim    16  computed time limit
//   drop_en  1   result final
//   busy     1   measurement in progress
//   overflow 1   measurement ended by saturation
// Revision    : 1.0 - initial release
// ============================================================================
interface baggage_timer_ctrl_if;
  logic        start;
  logic [7:0]  weight;
  logic        arrive;
  logic        clear;
  logic [15:0] t_act;
  logic [15:0] t_lim;
  logic        drop_en;
  logic        busy;
  logic        overflow;

  modport master (
    output start, weight, arrive, clear,
    input  t_act, t_lim, drop_en, busy, overflow
  );

  modport slave (
    input  start, weight, arrive, clear,
    output t_act, t_lim, drop_en, busy, overflow
  );
endinterface
`default_nettype wire

// File: rtl/baggage_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : baggage_timer_ctrl
// Description : Measurement stage ahead of the display/drop decision stage.
//               On start the baggage weight is captured and the time limit
//               t_lim is computed; elapsed ticks t_act are counted until the
//               baggage arrives, then t_act/t_lim are frozen with drop_en=1
//               until clear. t_act never equals t_lim while drop_en=1.
// Ports       :
//   clk   in   system clock, rising edge
//   rst   in   synchronous reset, active-high
//   bus   slave modport of baggage_timer_ctrl_if (start, weight, arrive,
//         clear in; t_act, t_lim, drop_en, busy, overflow out)
// Revision    : 1.0 - initial release
// ============================================================================
module baggage_timer_ctrl #(
  parameter int          TICK_DIV  = 4,
  parameter logic [15:0] LIM_BASE  = 16'd20,
  parameter logic [7:0]  LIM_SCALE = 8'd2
) (
  input  wire logic            clk,
  input  wire logic            rst,
  baggage_timer_ctrl_if.slave  bus
);

  // A one-cycle prescaler still needs a 1-bit register.
  localparam int            PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] c_presc_last = PW'(TICK_DIV - 1);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_load   = 2'd1;
  localparam logic [1:0] c_st_timing = 2'd2;
  localparam logic [1:0] c_st_done   = 2'd3;

  localparam logic [15:0] c_act_max = 16'hFFFF;
  localparam logic [16:0] c_lim_max = 17'h0FFFE;

  logic [1:0]    state_q, state_d;
  logic [7:0]    weight_q, weight_d;
  logic [15:0]   t_act_q, t_act_d;
  logic [15:0]   t_lim_q, t_lim_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          drop_en_q, drop_en_d;
  logic          busy_q, busy_d;
  logic          overflow_q, overflow_d;

  logic          tick;
  logic [15:0]   t_act_step;
  logic [16:0]   lim_sum;
  logic [15:0]   lim_sat;

  // Tick of the current cycle is folded in before any arrive/saturation test.
  assign tick       = (presc_q == c_presc_last);
  assign t_act_step = (tick && (t_act_q != c_act_max)) ? (t_act_q + 16'd1) : t_act_q;

  // Worst case 65535 + 255*255 still fits in 17 bits.
  assign lim_sum = {1'b0, LIM_BASE} + (17'(weight_q) * 17'(LIM_SCALE));
  // Capping at FFFE leaves FFFF free so a saturated t_act is always late.
  assign lim_sat = (lim_sum > c_lim_max) ? c_lim_max[15:0] : lim_sum[15:0];

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= c_st_idle;
      weight_q   <= 8'd0;
      t_act_q    <= 16'd0;
      t_lim_q    <= 16'd0;
      presc_q    <= '0;
      drop_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      weight_q   <= weight_d;
      t_act_q    <= t_act_d;
      t_lim_q    <= t_lim_d;
      presc_q    <= presc_d;
      drop_en_q  <= drop_en_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle: begin
        if (bus.start) state_d = c_st_load;
      end
      c_st_load: begin
        state_d = c_st_timing;
      end
      c_st_timing: begin
        if (bus.clear)                     state_d = c_st_idle;
        else if (bus.arrive)               state_d = c_st_done;
        else if (t_act_step == c_act_max)  state_d = c_st_done;
      end
      c_st_done: begin
        if (bus.clear) state_d = c_st_idle;
      end
      default: state_d = c_st_idle;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    weight_d   = weight_q;
    t_act_d    = t_act_q;
    t_lim_d    = t_lim_q;
    presc_d    = presc_q;
    overflow_d = overflow_q;
    case (state_q)
      c_st_idle: begin
        if (bus.start) weight_d = bus.weight;
      end
      c_st_load: begin
        t_lim_d = lim_sat;
        t_act_d = 16'd0;
        presc_d = '0;
      end
      c_st_timing: begin
        presc_d = tick ? '0 : (presc_q + PW'(1));
        if (bus.clear) begin
          t_act_d = 16'd0;
          t_lim_d = 16'd0;
          presc_d = '0;
        end else if (bus.arrive) begin
          // A tie counts as late; t_lim <= FFFE so +1 cannot wrap.
          t_act_d = (t_act_step == t_lim_q) ? (t_act_step + 16'd1) : t_act_step;
        end else begin
          t_act_d = t_act_step;
          if (t_act_step == c_act_max) overflow_d = 1'b1;
        end
      end
      c_st_done: begin
        if (bus.clear) begin
          t_act_d    = 16'd0;
          t_lim_d    = 16'd0;
          overflow_d = 1'b0;
        end
      end
      default: begin
        t_act_d    = 16'd0;
        t_lim_d    = 16'd0;
        overflow_d = 1'b0;
      end
    endcase
    drop_en_d = (state_d == c_st_done);
    busy_d    = (state_d != c_st_idle);
  end

  assign bus.t_act    = t_act_q;
  assign bus.t_lim    = t_lim_q;
  assign bus.drop_en  = drop_en_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_baggage_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_baggage_timer_ctrl
// Description : Self-checking bench for baggage_timer_ctrl. A default-parameter
//               instance runs directed and randomized measurements; a second
//               instance (LIM_BASE=FF00, TICK_DIV=1) runs the saturation case
//               in parallel. Expected values come from arithmetic on the
//               limit/tick rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_baggage_timer_ctrl;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst2 = 1'b1;

  baggage_timer_ctrl_if bus();
  baggage_timer_ctrl_if bus2();

  baggage_timer_ctrl #(
    .TICK_DIV (4),
    .LIM_BASE (16'd20),
    .LIM_SCALE(8'd2)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  baggage_timer_ctrl #(
    .TICK_DIV (1),
    .LIM_BASE (16'hFF00),
    .LIM_SCALE(8'd2)
  ) u_dut_sat (
    .clk(clk),
    .rst(rst2),
    .bus(bus2)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Limit rule: base + weight*scale, capped at FFFE.
  function automatic int ref_lim(input int w, input int base, input int scale);
    int s;
    s = base + w * scale;
    return (s > 65534) ? 65534 : s;
  endfunction

  // Reported t_act when arrive is seen in timing cycle j (j=0 first cycle).
  function automatic int ref_final(input int j, input int lim, input int div);
    int t;
    t = (j + 1) / div;
    if (t > 65535) t = 65535;
    if (t == lim) t = t + 1;
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string nm);
    check_val({nm, " idle t_act"},    32'(bus.t_act),    32'd0);
    check_val({nm, " idle t_lim"},    32'(bus.t_lim),    32'd0);
    check_val({nm, " idle drop_en"},  32'(bus.drop_en),  32'd0);
    check_val({nm, " idle busy"},     32'(bus.busy),     32'd0);
    check_val({nm, " idle overflow"}, 32'(bus.overflow), 32'd0);
  endtask

  // One full measurement: start, arrive in timing cycle ja, hold, clear.
  task automatic run_case(input string nm, input int w, input int ja, input bit arrive_with_start);
    int lim;
    int fin;
    lim = ref_lim(w, 20, 2);
    fin = ref_final(ja, lim, 4);
    bus.weight = 8'(w);
    bus.start  = 1'b1;
    bus.arrive = arrive_with_start;
    step();
    bus.start  = 1'b0;
    bus.arrive = 1'b0;
    bus.weight = 8'($urandom);
    check_val({nm, " load busy"},    32'(bus.busy),    32'd1);
    check_val({nm, " load drop_en"}, 32'(bus.drop_en), 32'd0);
    step();
    check_val({nm, " t_lim"},       32'(bus.t_lim), 32'(lim));
    check_val({nm, " t_act start"}, 32'(bus.t_act), 32'd0);
    for (int j = 0; j <= ja; j++) begin
      if ((j % 37) == 5) begin
        check_val({nm, " live t_act"}, 32'(bus.t_act), 32'(j / 4));
        check_val({nm, " live drop_en"}, 32'(bus.drop_en), 32'd0);
      end
      bus.arrive = (j == ja);
      bus.start  = (($urandom % 8) == 0);
      step();
      bus.arrive = 1'b0;
      bus.start  = 1'b0;
    end
    check_val({nm, " done drop_en"},  32'(bus.drop_en),  32'd1);
    check_val({nm, " done t_act"},    32'(bus.t_act),    32'(fin));
    check_val({nm, " done t_lim"},    32'(bus.t_lim),    32'(lim));
    check_val({nm, " done overflow"}, 32'(bus.overflow), 32'd0);
    check_val({nm, " done busy"},     32'(bus.busy),     32'd1);
    check_val({nm, " act!=lim"},      32'(bus.t_act != bus.t_lim), 32'd1);
    repeat (3) begin
      bus.start  = 1'($urandom);
      bus.arrive = 1'($urandom);
      step();
    end
    bus.start  = 1'b0;
    bus.arrive = 1'b0;
    check_val({nm, " hold t_act"},   32'(bus.t_act),   32'(fin));
    check_val({nm, " hold drop_en"}, 32'(bus.drop_en), 32'd1);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    check_idle({nm, " cleared"});
  endtask

  // Main sequence on the default-parameter instance.
  task automatic main_seq();
    int w;
    int lim;
    int ja;
    bus.start = 1'b0; bus.weight = 8'd0; bus.arrive = 1'b0; bus.clear = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    check_idle("reset");
    rst = 1'b0;
    step();

    run_case("t1 on-time", 10, 119, 1'b0);   // 30 ticks
    run_case("t2 late",    10, 199, 1'b0);   // 50 ticks
    run_case("t3 tie",     10, 159, 1'b0);   // 40 ticks -> 41
    run_case("t3b pre-tie", 10, 158, 1'b0);  // 39 ticks
    run_case("start+arrive idle", 3, 20, 1'b1);

    // Start ignored in timing, then abort with clear (clear beats arrive).
    bus.weight = 8'd10; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    for (int j = 0; j < 20; j++) begin
      bus.start  = 1'b1;
      bus.weight = 8'd200;
      step();
    end
    bus.start = 1'b0;
    check_val("t5 t_lim kept", 32'(bus.t_lim), 32'd40);
    check_val("t5 t_act live", 32'(bus.t_act), 32'd5);
    bus.clear = 1'b1; bus.arrive = 1'b1;
    step();
    bus.clear = 1'b0; bus.arrive = 1'b0;
    check_idle("t5 abort");
    bus.arrive = 1'b1;
    step();
    bus.arrive = 1'b0;
    check_idle("t5 arrive in idle");
    run_case("t5 rerun", 10, 87, 1'b0);

    // Reset mid-timing at tick 7.
    bus.weight = 8'd10; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    repeat (28) step();
    check_val("t6 t_act before rst", 32'(bus.t_act), 32'd7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("t6 reset");
    bus.arrive = 1'b1;
    step();
    bus.arrive = 1'b0;
    check_idle("t6 arrive after rst");

    // Randomized runs, about a third landing exactly on the tie point.
    for (int k = 0; k < 15; k++) begin
      w   = int'($urandom_range(0, 40));
      lim = ref_lim(w, 20, 2);
      if (($urandom % 3) == 0) ja = 4 * lim - 1;
      else                     ja = int'($urandom_range(0, 4 * lim + 60));
      run_case($sformatf("rnd%0d", k), w, ja, 1'($urandom));
    end
  endtask

  // Saturation case on the TICK_DIV=1, LIM_BASE=FF00 instance.
  task automatic sat_seq();
    int j;
    bit seen;
    bus2.start = 1'b0; bus2.weight = 8'd0; bus2.arrive = 1'b0; bus2.clear = 1'b0;
    rst2 = 1'b1;
    repeat (3) step();
    check_val("t4 reset busy",  32'(bus2.busy),  32'd0);
    check_val("t4 reset t_lim", 32'(bus2.t_lim), 32'd0);
    rst2 = 1'b0;
    step();
    bus2.weight = 8'd255; bus2.start = 1'b1;
    step();
    bus2.start = 1'b0;
    step();
    check_val("t4 t_lim", 32'(bus2.t_lim), 32'(ref_lim(255, 32'hFF00, 2)));
    j = 0;
    seen = 1'b0;
    while (j < 70000) begin
      if (bus2.drop_en) begin
        seen = 1'b1;
        break;
      end
      if (j == 32'hFFFE) begin
        check_val("t4 t_act at FFFE", 32'(bus2.t_act), 32'hFFFE);
        check_val("t4 overflow early", 32'(bus2.overflow), 32'd0);
      end
      step();
      j++;
    end
    check_val("t4 done reached", 32'(seen), 32'd1);
    check_val("t4 done cycle",   32'(j), 32'hFFFF);
    check_val("t4 t_act",        32'(bus2.t_act),    32'hFFFF);
    check_val("t4 overflow",     32'(bus2.overflow), 32'd1);
    check_val("t4 busy",         32'(bus2.busy),     32'd1);
    step();
    check_val("t4 hold t_act",   32'(bus2.t_act),    32'hFFFF);
    bus2.clear = 1'b1;
    step();
    bus2.clear = 1'b0;
    check_val("t4 clr overflow", 32'(bus2.overflow), 32'd0);
    check_val("t4 clr drop_en",  32'(bus2.drop_en),  32'd0);
    check_val("t4 clr t_act",    32'(bus2.t_act),    32'd0);
  endtask

  initial begin
    fork
      main_seq();
      sat_seq();
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
